// File: rtl/accu_pkg.sv
// Shared types and sizing helpers for the accumulator datapath.
package accu_pkg;

    // The sum width that holds N samples of W bits without overflow.
    function automatic int unsigned sum_width(input int unsigned w, input int unsigned n);
        return w + $clog2(n);
    endfunction

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/accu_out_reg.sv
// One-entry valid/ready holding register for a {data,count} result.
module accu_out_reg
    import accu_pkg::*;
#(
    parameter int unsigned DW = 19,
    parameter int unsigned CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [DW-1:0] load_data,
    input  logic [CW-1:0] load_count,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic [CW-1:0] out_count,
    output logic          slot_free_c
);

    out_state_e state_q;
    out_state_e state_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= OUT_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // A load always lands in FULL; consuming without a load empties the slot.
    always_comb begin
        state_d = state_q;
        case (state_q)
            OUT_EMPTY: begin
                if (load) state_d = OUT_FULL;
            end
            OUT_FULL: begin
                if (!load && out_ready) state_d = OUT_EMPTY;
            end
        endcase
    end

    // Payload only changes on load, so it stays stable through a stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data  <= '0;
            out_count <= '0;
        end else if (load) begin
            out_data  <= load_data;
            out_count <= load_count;
        end
    end

    assign out_valid   = (state_q == OUT_FULL);
    assign slot_free_c = (state_q == OUT_EMPTY) || out_ready;

endmodule

// File: rtl/accu_dump.sv
// Accumulate-and-dump decimator: sums N accepted samples per window,
// with an early flush of a partial window.
module accu_dump
    import accu_pkg::*;
#(
    parameter int unsigned W    = 16,
    parameter int unsigned N    = 8,
    localparam int unsigned OW  = sum_width(W, N),
    localparam int unsigned CW  = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] out_data,
    output logic [CW-1:0] out_count
);

    logic [OW-1:0] acc_q;
    logic [OW-1:0] acc_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          pend_q;
    logic          pend_d;

    logic          slot_free_c;
    logic          last_c;
    logic          accept_c;
    logic          flush_req_c;
    logic          dump_full_c;
    logic          dump_flush_c;
    logic          load_c;
    logic [OW-1:0] add_c;
    logic [OW-1:0] load_data_c;
    logic [CW-1:0] load_count_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
        end
    end

    // Only the last sample of a window waits for the output slot.
    always_comb begin
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        pend_d       = pend_q;
        last_c       = (cnt_q == CW'(N - 1));
        in_ready     = !(last_c && !slot_free_c);
        accept_c     = in_valid && in_ready;
        add_c        = accept_c ? OW'(in_data) : '0;
        flush_req_c  = (flush || pend_q) && (cnt_q != '0);
        dump_full_c  = accept_c && last_c;
        dump_flush_c = flush_req_c && slot_free_c && !dump_full_c;
        load_c       = dump_full_c || dump_flush_c;
        load_data_c  = acc_q + add_c;
        load_count_c = cnt_q + CW'(accept_c);

        if (load_c) begin
            acc_d  = '0;
            cnt_d  = '0;
            pend_d = 1'b0;
        end else begin
            if (accept_c) begin
                acc_d = load_data_c;
                cnt_d = load_count_c;
            end
            // A blocked flush is remembered and retried every cycle.
            if (flush_req_c) pend_d = 1'b1;
        end
    end

    accu_out_reg #(
        .DW (OW),
        .CW (CW)
    ) u_out_reg (
        .clk         (clk),
        .rst         (rst),
        .load        (load_c),
        .load_data   (load_data_c),
        .load_count  (load_count_c),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_count   (out_count),
        .slot_free_c (slot_free_c)
    );

endmodule

// File: tb/tb_accu_dump.sv
// Bench for accu_dump: window-list model checked every cycle plus directed literals.
module tb_accu_dump;

    localparam int unsigned W  = 16;
    localparam int unsigned N  = 8;
    localparam int unsigned OW = W + $clog2(N);
    localparam int unsigned CW = $clog2(N + 1);

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_data;
    logic [CW-1:0] out_count;

    int n_chk  = 0;
    int n_fail = 0;

    accu_dump #(.W(W), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: the open window is a list of samples; a result is its plain sum.
    int unsigned   win[$];
    bit            m_valid = 1'b0;
    longint        m_data  = 0;
    longint        m_count = 0;
    bit            m_pend  = 1'b0;
    longint        got_data[$];
    longint        got_count[$];
    bit            mb_sf;
    bit            mb_acc;

    function automatic bit m_slot_free();
        return !m_valid || out_ready;
    endfunction

    function automatic bit m_ready();
        return !((win.size() == N - 1) && !m_slot_free());
    endfunction

    function automatic longint wsum();
        longint s = 0;
        foreach (win[i]) s += win[i];
        return s;
    endfunction

    always @(negedge rst) begin
        win.delete();
        m_valid = 1'b0;
        m_data  = 0;
        m_count = 0;
        m_pend  = 1'b0;
    end

    always @(posedge clk) begin
        if (rst) begin
            if (out_valid && out_ready) begin
                got_data.push_back(longint'(out_data));
                got_count.push_back(longint'(out_count));
            end
            mb_sf  = m_slot_free();
            mb_acc = in_valid && m_ready();
            if (mb_acc && win.size() == N - 1) begin
                win.push_back(in_data);
                m_data  = wsum();
                m_count = win.size();
                m_valid = 1'b1;
                m_pend  = 1'b0;
                win.delete();
            end else if ((flush || m_pend) && win.size() > 0 && mb_sf) begin
                if (mb_acc) win.push_back(in_data);
                m_data  = wsum();
                m_count = win.size();
                m_valid = 1'b1;
                m_pend  = 1'b0;
                win.delete();
            end else begin
                if (flush && win.size() > 0) m_pend = 1'b1;
                if (mb_acc) win.push_back(in_data);
                if (out_ready) m_valid = 1'b0;
            end
        end
    end

    // Every-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            check("model out_valid", out_valid, m_valid);
            check("model in_ready", in_ready, m_ready());
            if (m_valid) begin
                check("model out_data", out_data, m_data);
                check("model out_count", out_count, m_count);
            end
        end
    end

    task automatic clear_got();
        got_data.delete();
        got_count.delete();
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (3) step();
        check("reset out_valid", out_valid, 0);
        check("reset out_data", out_data, 0);
        check("reset out_count", out_count, 0);
        rst = 1'b1;
        #1;
        check("in_ready after reset", in_ready, 1);

        // 1: window 1..8 with output always ready
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_data = W'(i);
            step();
        end
        in_valid = 1'b0;
        check("t1 out_valid", out_valid, 1);
        check("t1 out_data", out_data, 36);
        check("t1 out_count", out_count, 8);
        step();
        check("t1 pulse ends", out_valid, 0);

        // 2: full-scale samples, then a fresh window via flush-at-zero sample
        in_valid = 1'b1;
        in_data  = 16'hFFFF;
        repeat (8) step();
        in_valid = 1'b0;
        check("t2 max sum", out_data, 20'h7FFF8);
        check("t2 count", out_count, 8);
        in_valid = 1'b1;
        in_data  = 16'd5;
        flush    = 1'b1;
        step();
        in_valid = 1'b0;
        check("t2 flush at zero", out_valid, 0);
        step();
        flush = 1'b0;
        check("t2 fresh window sum", out_data, 5);
        check("t2 fresh window count", out_count, 1);
        step();

        // 3: output stalls while the next window streams in
        clear_got();
        in_valid = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_data = W'(i);
            step();
        end
        out_ready = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            in_data = W'(i);
            check("t3 early accept", in_ready, 1);
            step();
        end
        in_data = 16'd8;
        check("t3 8th blocked", in_ready, 0);
        step();
        check("t3 held data", out_data, 36);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("t3 back-to-back valid", out_valid, 1);
        check("t3 second sum", out_data, 36);
        step();
        check("t3 result count", got_data.size(), 2);
        if (got_data.size() == 2) begin
            check("t3 first delivered", got_data[0], 36);
            check("t3 second delivered", got_data[1], 36);
        end

        // 4: flush a partial window of 5,6,7; flush at zero does nothing
        in_valid = 1'b1;
        for (int i = 5; i <= 7; i++) begin
            in_data = W'(i);
            step();
        end
        in_valid = 1'b0;
        flush    = 1'b1;
        step();
        flush = 1'b0;
        check("t4 flush data", out_data, 18);
        check("t4 flush count", out_count, 3);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("t4 empty flush", out_valid, 0);
        step();
        check("t4 still empty", out_valid, 0);

        // 5: flush while the output is full and stalled
        clear_got();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'd2;
        repeat (8) step();
        in_data = 16'd1;
        step();
        in_data = 16'd2;
        step();
        in_valid = 1'b0;
        flush    = 1'b1;
        step();
        flush = 1'b0;
        repeat (2) step();
        check("t5 stalled data", out_data, 16);
        in_valid = 1'b1;
        in_data  = 16'd4;
        step();
        in_valid = 1'b0;
        step();
        out_ready = 1'b1;
        step();
        check("t5 flushed valid", out_valid, 1);
        check("t5 flushed data", out_data, 7);
        check("t5 flushed count", out_count, 3);
        step();
        check("t5 result count", got_data.size(), 2);
        if (got_data.size() == 2) begin
            check("t5 prior result", got_data[0], 16);
            check("t5 flushed result", got_data[1], 7);
            check("t5 flushed cnt", got_count[1], 3);
        end

        // 6: asynchronous reset mid-window with a held result
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'd9;
        repeat (8) step();
        in_data = 16'd1;
        repeat (3) step();
        in_valid = 1'b0;
        check("t6 held before reset", out_valid, 1);
        #2;
        rst = 1'b0;
        #1;
        check("t6 async clear", out_valid, 0);
        repeat (2) step();
        clear_got();
        rst       = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_data = W'(i);
            step();
        end
        in_valid = 1'b0;
        repeat (2) step();
        check("t6 result count", got_data.size(), 1);
        if (got_data.size() == 1) begin
            check("t6 new sum", got_data[0], 36);
            check("t6 new count", got_count[0], 8);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
